// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper: FSM states, glyph codes
// and the object-type to point-value mapping.
package score_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    CHECK,
    DRAW,
    GAP,
    DONE
  } state_t;

  localparam logic [4:0] GLYPH_BLANK = 5'd15;

  localparam logic [4:0] OBJ_SMALL_GOLD = 5'd10;
  localparam logic [4:0] OBJ_LARGE_GOLD = 5'd11;
  localparam logic [4:0] OBJ_DIAMOND    = 5'd12;
  localparam logic [4:0] OBJ_ROCK       = 5'd13;
  localparam logic [4:0] OBJ_BONE       = 5'd14;

  // Three BCD digits of points per object; unknown objects score nothing.
  function automatic logic [11:0] obj_points(input logic [4:0] obj);
    case (obj)
      OBJ_SMALL_GOLD: obj_points = 12'h050;
      OBJ_LARGE_GOLD: obj_points = 12'h200;
      OBJ_DIAMOND:    obj_points = 12'h500;
      OBJ_ROCK:       obj_points = 12'h020;
      OBJ_BONE:       obj_points = 12'h010;
      default:        obj_points = 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/score_bcd_display_add.sv
// Single-digit BCD adder with carry; the score keeper reuses one instance
// serially across all digits.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw > 5'd9) begin
      sum  = 4'(raw - 5'd10);
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// BCD score keeper: digit-serial add with saturation, target compare, and a
// per-digit redraw through the shared draw engine with leading-zero blanking.
module score_bcd_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_X0    = 51,
  parameter int DIGIT_PITCH = 8,
  parameter int DIGIT_Y     = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_score,
  input  logic [4:0]              obj_type,
  input  logic                    start_update,
  input  logic                    redraw_only,
  input  logic [4*NUM_DIGITS-1:0] target_bcd,
  input  logic                    draw_done,
  output logic                    start_draw,
  output logic [8:0]              draw_x,
  output logic [7:0]              draw_y,
  output logic [4:0]              draw_glyph,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    target_met,
  output logic                    overflow,
  output logic                    busy,
  output logic                    update_done
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [4:0]      obj_q;
  logic            carry;
  logic            clear_pend;
  logic [SW-1:0]   pts_ext;
  logic [SW-1:0]   score_sat;
  logic [3:0]      cur_digit;
  logic [3:0]      pt_digit;
  logic [3:0]      sum_digit;
  logic            sum_carry;
  logic [NUM_DIGITS-1:0] zero_from;
  logic            leave_done;

  assign pts_ext    = SW'(obj_points(obj_q));
  assign cur_digit  = score_bcd[idx*4 +: 4];
  assign pt_digit   = pts_ext[idx*4 +: 4];
  assign score_sat  = carry ? ALL_NINES : score_bcd;
  assign leave_done = !start_update && !redraw_only;

  bcd_digit_add u_add (
    .a    (cur_digit),
    .b    (pt_digit),
    .cin  (carry),
    .sum  (sum_digit),
    .cout (sum_carry)
  );

  // zero_from[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic run;
    run = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run && (score_bcd[i*4 +: 4] == 4'd0);
      zero_from[i] = run;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_draw  = 1'b0;
    draw_x      = '0;
    draw_y      = '0;
    draw_glyph  = '0;
    update_done = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (clear_score)       state_nxt = IDLE;
        else if (start_update) state_nxt = ADD;
        else if (redraw_only)  state_nxt = DRAW;
      end
      ADD:   if (idx == LAST) state_nxt = CHECK;
      CHECK: state_nxt = DRAW;
      DRAW: begin
        start_draw = 1'b1;
        draw_x     = 9'(DIGIT_X0 + (NUM_DIGITS - 1 - int'(idx)) * DIGIT_PITCH);
        draw_y     = 8'(DIGIT_Y);
        draw_glyph = (idx != '0 && zero_from[idx]) ? GLYPH_BLANK : {1'b0, cur_digit};
        if (draw_done) state_nxt = (idx == '0) ? DONE : GAP;
      end
      GAP:  state_nxt = DRAW;
      DONE: begin
        update_done = 1'b1;
        if (leave_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A clear seen mid-operation is deferred until the FSM returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd  <= '0;
      target_met <= 1'b0;
      overflow   <= 1'b0;
      clear_pend <= 1'b0;
      idx        <= '0;
      obj_q      <= '0;
      carry      <= 1'b0;
    end else begin
      if (state != IDLE && clear_score) clear_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_score) begin
            score_bcd  <= '0;
            overflow   <= 1'b0;
            target_met <= 1'b0;
            clear_pend <= 1'b0;
          end else if (start_update) begin
            obj_q <= obj_type;
            idx   <= '0;
            carry <= 1'b0;
          end else if (redraw_only) begin
            idx <= LAST;
          end
        end
        ADD: begin
          score_bcd[idx*4 +: 4] <= sum_digit;
          carry <= sum_carry;
          if (idx != LAST) idx <= idx + IW'(1);
        end
        CHECK: begin
          if (carry) begin
            score_bcd <= ALL_NINES;
            overflow  <= 1'b1;
          end
          target_met <= (score_sat >= target_bcd);
          idx        <= LAST;
        end
        GAP: idx <= idx - IW'(1);
        DONE: begin
          if (leave_done && (clear_pend || clear_score)) begin
            score_bcd  <= '0;
            overflow   <= 1'b0;
            target_met <= 1'b0;
            clear_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display: a table of update/redraw operations
// with expected score and flags, plus sequences for clear and async reset.
module tb_score_bcd_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_score;
  logic [4:0]  obj_type;
  logic        start_update;
  logic        redraw_only;
  logic [15:0] target_bcd;
  logic        draw_done;
  logic        start_draw;
  logic [8:0]  draw_x;
  logic [7:0]  draw_y;
  logic [4:0]  draw_glyph;
  logic [15:0] score_bcd;
  logic        target_met;
  logic        overflow;
  logic        busy;
  logic        update_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_bcd_display dut (
    .clk          (clk),
    .reset        (reset),
    .clear_score  (clear_score),
    .obj_type     (obj_type),
    .start_update (start_update),
    .redraw_only  (redraw_only),
    .target_bcd   (target_bcd),
    .draw_done    (draw_done),
    .start_draw   (start_draw),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_glyph   (draw_glyph),
    .score_bcd    (score_bcd),
    .target_met   (target_met),
    .overflow     (overflow),
    .busy         (busy),
    .update_done  (update_done)
  );

  typedef struct {
    logic        upd;
    logic [4:0]  typ;
    logic [15:0] exp_score;
    logic        exp_ov;
    logic        exp_tm;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Expected glyph sequence, MSD first in [19:15].
  function automatic logic [19:0] glyphs_of(input logic [15:0] s);
    logic [19:0] r;
    logic        z;
    logic [3:0]  d;
    z = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      d = s[i*4 +: 4];
      z = z && (d == 4'd0);
      r[i*5 +: 5] = (z && i != 0) ? 5'd15 : {1'b0, d};
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic upd, input logic [4:0] typ,
                               output logic [19:0] glyphs, output int lat,
                               output int gap_err, output int xy_err,
                               output int done_err, output int timeout);
    int cyc;
    glyphs = '0; lat = -1; gap_err = 0; xy_err = 0; done_err = 0; timeout = 0;
    @(negedge clk);
    obj_type = typ; start_update = upd; redraw_only = !upd;
    @(negedge clk);
    start_update = 1'b0; redraw_only = 1'b0;
    cyc = 1;
    for (int n = 0; n < 4; n++) begin
      while (!start_draw && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      if (!start_draw) begin
        timeout = 1;
        break;
      end
      if (n == 0) lat = cyc;
      glyphs = {glyphs[14:0], draw_glyph};
      if (draw_x != 9'(51 + 8 * n) || draw_y != 8'd9) xy_err++;
      draw_done = 1'b1;
      @(negedge clk);
      cyc++;
      draw_done = 1'b0;
      if (n < 3) begin
        if (start_draw || !busy || draw_x != 9'd0 || draw_glyph != 5'd0) gap_err++;
        @(negedge clk);
        cyc++;
        if (!start_draw) gap_err++;
      end else begin
        if (!update_done || !busy) done_err++;
        @(negedge clk);
        if (busy || update_done) done_err++;
      end
    end
  endtask

  task automatic add_vec(input logic upd, input logic [4:0] typ, input logic [15:0] s,
                         input logic ov, input logic tm);
    vec_t v;
    v.upd = upd; v.typ = typ; v.exp_score = s; v.exp_ov = ov; v.exp_tm = tm;
    v.exp_lat = upd ? 6 : 1;
    vecs.push_back(v);
  endtask

  logic [19:0] g;
  int lat, ge, xe, de, to;

  initial begin
    reset = 1'b1; clear_score = 1'b0; obj_type = '0; start_update = 1'b0;
    redraw_only = 1'b0; target_bcd = 16'h0100; draw_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_score", 32'(score_bcd), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_start_draw", 32'(start_draw), 32'h0);
    checkOutput("reset_flags", 32'({overflow, target_met, update_done}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    add_vec(1, 5'd10, 16'h0050, 0, 0);
    add_vec(1, 5'd10, 16'h0100, 0, 1);
    add_vec(1, 5'd7,  16'h0100, 0, 1);
    add_vec(0, 5'd0,  16'h0100, 0, 1);
    add_vec(1, 5'd12, 16'h0600, 0, 1);
    add_vec(1, 5'd11, 16'h0800, 0, 1);
    add_vec(1, 5'd10, 16'h0850, 0, 1);
    add_vec(1, 5'd10, 16'h0900, 0, 1);
    add_vec(1, 5'd10, 16'h0950, 0, 1);
    add_vec(1, 5'd11, 16'h1150, 0, 1);
    for (int k = 1; k <= 17; k++) add_vec(1, 5'd12, to_bcd(1150 + 500 * k), 0, 1);
    add_vec(1, 5'd11, 16'h9850, 0, 1);
    add_vec(1, 5'd10, 16'h9900, 0, 1);
    add_vec(1, 5'd10, 16'h9950, 0, 1);
    add_vec(1, 5'd13, 16'h9970, 0, 1);
    add_vec(1, 5'd13, 16'h9990, 0, 1);
    add_vec(1, 5'd13, 16'h9999, 1, 1);
    add_vec(1, 5'd14, 16'h9999, 1, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].upd, vecs[i].typ, g, lat, ge, xe, de, to);
      checkOutput($sformatf("v%0d_timeout", i), 32'(to), 32'h0);
      checkOutput($sformatf("v%0d_score", i), 32'(score_bcd), 32'(vecs[i].exp_score));
      checkOutput($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ov));
      checkOutput($sformatf("v%0d_target_met", i), 32'(target_met), 32'(vecs[i].exp_tm));
      checkOutput($sformatf("v%0d_glyphs", i), 32'(g), 32'(glyphs_of(vecs[i].exp_score)));
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_gap", i), 32'(ge), 32'h0);
      checkOutput($sformatf("v%0d_xy", i), 32'(xe), 32'h0);
      checkOutput($sformatf("v%0d_done", i), 32'(de), 32'h0);
      if (i == 0) checkOutput("first_glyphs_literal", 32'(g), 32'({5'd15, 5'd15, 5'd5, 5'd0}));
    end

    // Clear requested mid-draw takes effect only once back in IDLE.
    @(negedge clk);
    obj_type = 5'd7; start_update = 1'b1;
    @(negedge clk);
    start_update = 1'b0;
    for (int w = 0; w < 50 && !start_draw; w++) @(negedge clk);
    checkOutput("clr_reach_draw", 32'(start_draw), 32'h1);
    clear_score = 1'b1;
    @(negedge clk);
    clear_score = 1'b0;
    checkOutput("clr_score_held", 32'(score_bcd), 32'h9999);
    for (int n = 0; n < 4; n++) begin
      for (int w = 0; w < 50 && !start_draw; w++) @(negedge clk);
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
    end
    checkOutput("clr_in_done", 32'({update_done, score_bcd}), 32'h19999);
    @(negedge clk);
    checkOutput("clr_applied", 32'({busy, overflow, target_met, score_bcd}), 32'h0);

    applyStimulus(1'b0, 5'd0, g, lat, ge, xe, de, to);
    checkOutput("redraw_glyphs", 32'(g), 32'({5'd15, 5'd15, 5'd15, 5'd0}));
    checkOutput("redraw_latency", 32'(lat), 32'd1);
    checkOutput("redraw_score", 32'(score_bcd), 32'h0);

    // Clear in IDLE beats a simultaneous start_update.
    applyStimulus(1'b1, 5'd10, g, lat, ge, xe, de, to);
    checkOutput("pre_clr_score", 32'(score_bcd), 32'h0050);
    @(negedge clk);
    clear_score = 1'b1; start_update = 1'b1; obj_type = 5'd12;
    @(negedge clk);
    clear_score = 1'b0; start_update = 1'b0;
    checkOutput("idle_clr_busy", 32'(busy), 32'h0);
    checkOutput("idle_clr_score", 32'(score_bcd), 32'h0);
    @(negedge clk);
    checkOutput("idle_clr_no_op", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a draw.
    obj_type = 5'd10; start_update = 1'b1;
    @(negedge clk);
    start_update = 1'b0;
    for (int w = 0; w < 50 && !start_draw; w++) @(negedge clk);
    checkOutput("rst_reach_draw", 32'({start_draw, score_bcd}), 32'h10050);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async", 32'({start_draw, busy, score_bcd}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd10, g, lat, ge, xe, de, to);
    checkOutput("rst_after_score", 32'(score_bcd), 32'h0050);
    checkOutput("rst_after_glyphs", 32'(g), 32'({5'd15, 5'd15, 5'd5, 5'd0}));
    checkOutput("rst_after_latency", 32'(lat), 32'd6);
    checkOutput("rst_after_flags", 32'({overflow, target_met}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
